// File: rtl/clock_pkg.sv
// ============================================================================
// Module : clock_pkg
// Brief  : Shared constants for the tick_gen timebase (blink modes, default clock).
// Rev    : 1.0
// ============================================================================
`default_nettype none

package clock_pkg;

    localparam int unsigned C_CLK_HZ_DEFAULT = 50_000_000;

    localparam logic [1:0] BLINK_OFF = 2'd0;
    localparam logic [1:0] BLINK_ON  = 2'd1;
    localparam logic [1:0] BLINK_1HZ = 2'd2;
    localparam logic [1:0] BLINK_2HZ = 2'd3;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module : tick_prescaler
// Brief  : Mod-N counter with enable and sync clear; o_wrap flags the terminal count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap
);

    localparam logic [W-1:0] C_LAST = W'(N - 1);

    logic [W-1:0] r_cnt;
    logic         w_wrap;

    // Clear wins over enable, so no wrap pulse is issued on a clear cycle.
    assign w_wrap = i_en & ~i_clr & (r_cnt == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = w_wrap;

endmodule

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// Module : tick_gen
// Brief  : 1 Hz / sub-second timebase with pause, sync restart and blink output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tick_gen
    import clock_pkg::*;
#(
    parameter int CLK_HZ  = C_CLK_HZ_DEFAULT,
    parameter int SUB_DIV = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       run,
    input  logic                       clr,
    input  logic [1:0]                 blink_mode,
    output logic                       en1hz,
    output logic                       en_sub,
    output logic [$clog2(SUB_DIV)-1:0] slice,
    output logic                       blink
);

    localparam int SLICE = CLK_HZ / SUB_DIV;
    localparam int CW    = (SLICE > 1) ? $clog2(SLICE) : 1;
    localparam int SW    = $clog2(SUB_DIV);

    localparam logic [CW-1:0] C_SLICE_LAST = CW'(SLICE - 1);
    localparam logic [SW-1:0] C_HALF       = SW'(SUB_DIV / 2);
    localparam logic [SW-1:0] C_QTR        = SW'(SUB_DIV / 4);

    if (SUB_DIV % 4 != 0) begin : g_err_subdiv
        $error("tick_gen: SUB_DIV must be a multiple of 4");
    end
    if (CLK_HZ % SUB_DIV != 0) begin : g_err_div
        $error("tick_gen: CLK_HZ must be divisible by SUB_DIV");
    end
    if (SLICE < 2) begin : g_err_slice
        $error("tick_gen: CLK_HZ/SUB_DIV must be at least 2");
    end

    logic [CW-1:0] w_cyc_cnt;
    logic          w_cyc_wrap;
    logic          w_en_sub;
    logic [SW-1:0] w_slice;
    logic          w_sec_wrap;
    logic          w_blink_d;
    logic          r_blink;

    tick_prescaler #(.N(SLICE), .W(CW)) u_cyc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (run),
        .i_clr  (clr),
        .o_cnt  (w_cyc_cnt),
        .o_wrap (w_cyc_wrap)
    );

    assign w_en_sub = w_cyc_wrap & (w_cyc_cnt == C_SLICE_LAST);

    tick_prescaler #(.N(SUB_DIV), .W(SW)) u_slice (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_en_sub),
        .i_clr  (clr),
        .o_cnt  (w_slice),
        .o_wrap (w_sec_wrap)
    );

    // Blink tracks the held slice even while paused; no phase reset on mode change.
    always_comb begin
        w_blink_d = 1'b0;
        case (blink_mode)
            BLINK_OFF: w_blink_d = 1'b0;
            BLINK_ON:  w_blink_d = 1'b1;
            BLINK_1HZ: w_blink_d = (w_slice < C_HALF);
            BLINK_2HZ: w_blink_d = ((w_slice % C_HALF) < C_QTR);
            default:   w_blink_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink <= 1'b0;
        end else begin
            r_blink <= w_blink_d;
        end
    end

    assign en_sub = w_en_sub;
    assign en1hz  = w_sec_wrap;
    assign slice  = w_slice;
    assign blink  = r_blink;

endmodule

`default_nettype wire
